// File: rtl/pwm_gen.sv
// Double-buffered up-counter PWM source with a per-cycle strobe.
// New period/duty values staged while running take effect only on a wrap, so no runt pulses reach the pin.
module pwm_gen #(
  parameter int          WIDTH      = 8,
  parameter int unsigned RST_PERIOD = 255
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] period_in,
  input  logic [WIDTH-1:0] duty_in,
  output logic             pend,
  output logic             pwm_out,
  output logic             cycle_end
);

  localparam logic [WIDTH-1:0] RST_P = WIDTH'(RST_PERIOD);

  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] period_reg, period_next;
  logic [WIDTH-1:0] duty_reg, duty_next;
  logic [WIDTH-1:0] stage_period_reg, stage_period_next;
  logic [WIDTH-1:0] stage_duty_reg, stage_duty_next;
  logic             pend_reg, pend_next;
  logic             pwm_reg, pwm_next;
  logic             cycle_end_reg, cycle_end_next;
  logic             at_wrap;

  assign at_wrap = (cnt_reg == period_reg);

  always_comb begin
    cnt_next          = cnt_reg;
    period_next       = period_reg;
    duty_next         = duty_reg;
    stage_period_next = stage_period_reg;
    stage_duty_next   = stage_duty_reg;
    pend_next         = pend_reg;
    pwm_next          = 1'b0;
    cycle_end_next    = 1'b0;

    if (en) begin
      cnt_next       = at_wrap ? '0 : cnt_reg + 1'b1;
      pwm_next       = (cnt_reg < duty_reg);
      cycle_end_next = at_wrap;
      if (at_wrap) begin
        // A load landing on the wrap clock is newer than anything staged, so it wins outright.
        if (load) begin
          period_next = period_in;
          duty_next   = duty_in;
          pend_next   = 1'b0;
        end else if (pend_reg) begin
          period_next = stage_period_reg;
          duty_next   = stage_duty_reg;
          pend_next   = 1'b0;
        end
      end else if (load) begin
        stage_period_next = period_in;
        stage_duty_next   = duty_in;
        pend_next         = 1'b1;
      end
    end else begin
      cnt_next = '0;
      // While parked there is no waveform to protect; write the active pair directly.
      if (load) begin
        period_next = period_in;
        duty_next   = duty_in;
        pend_next   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      cnt_reg          <= '0;
      period_reg       <= RST_P;
      duty_reg         <= '0;
      stage_period_reg <= RST_P;
      stage_duty_reg   <= '0;
      pend_reg         <= 1'b0;
      pwm_reg          <= 1'b0;
      cycle_end_reg    <= 1'b0;
    end else begin
      cnt_reg          <= cnt_next;
      period_reg       <= period_next;
      duty_reg         <= duty_next;
      stage_period_reg <= stage_period_next;
      stage_duty_reg   <= stage_duty_next;
      pend_reg         <= pend_next;
      pwm_reg          <= pwm_next;
      cycle_end_reg    <= cycle_end_next;
    end
  end

  assign pend      = pend_reg;
  assign pwm_out   = pwm_reg;
  assign cycle_end = cycle_end_reg;

endmodule

// File: tb/tb_pwm_gen.sv
// Scoreboard bench for pwm_gen: stimulus queues hand-derived expected outputs per clock,
// a negedge monitor pops and compares them against pend/pwm_out/cycle_end.
module tb_pwm_gen;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [7:0] period_in = '0;
  logic [7:0] duty_in = '0;
  logic       pend;
  logic       pwm_out;
  logic       cycle_end;

  typedef struct {
    logic  pend;
    logic  pwm;
    logic  ce;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  int   edge_no = 0;

  pwm_gen #(.WIDTH(8), .RST_PERIOD(255)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .load      (load),
    .period_in (period_in),
    .duty_in   (duty_in),
    .pend      (pend),
    .pwm_out   (pwm_out),
    .cycle_end (cycle_end)
  );

  always #5 clk = ~clk;

  // One clock: drive inputs, wait the edge, then queue what the outputs must show after it.
  task automatic cyc(input logic r, input logic e, input logic l,
                     input logic [7:0] p, input logic [7:0] d,
                     input logic ep, input logic epwm, input logic ece,
                     input string tag);
    exp_t x;
    rstn = r; en = e; load = l; period_in = p; duty_in = d;
    @(posedge clk);
    x.pend = ep; x.pwm = epwm; x.ce = ece; x.tag = tag;
    exp_q.push_back(x);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      edge_no++;
      checks++;
      if (pend === x.pend && pwm_out === x.pwm && cycle_end === x.ce) begin
        passed++;
      end else begin
        $display("FAIL %s edge %0d: got pend=%b pwm_out=%b cycle_end=%b, expected pend=%b pwm_out=%b cycle_end=%b",
                 x.tag, edge_no, pend, pwm_out, cycle_end, x.pend, x.pwm, x.ce);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held two clocks, then parked load of period 9 / duty 3.
    cyc(1, 0, 0, 8'd0, 8'd0, 0, 0, 0, "reset");
    cyc(1, 0, 0, 8'd0, 8'd0, 0, 0, 0, "reset");
    cyc(0, 0, 1, 8'd9, 8'd3, 0, 0, 0, "parked_load");

    // 3 high / 7 low, strobe every 10 clocks.
    for (int k = 0; k < 20; k++)
      cyc(0, 1, 0, 8'd0, 8'd0, 0, (k % 10) < 3, (k % 10) == 9, "basic");

    // Staged load at cnt=4 waits for the wrap, then 2H/3L with period 4.
    for (int k = 0; k < 10; k++)
      cyc(0, 1, k == 4, 8'd4, 8'd2, (k >= 4 && k < 9), (k % 10) < 3, (k % 10) == 9, "dbuf_old");
    for (int k = 0; k < 10; k++)
      cyc(0, 1, 0, 8'd0, 8'd0, 0, (k % 5) < 2, (k % 5) == 4, "dbuf_new");

    // Load duty 5 at cnt=1, overwrite with duty 6 on the wrap clock (cnt=4).
    for (int k = 0; k < 5; k++)
      cyc(0, 1, (k == 1 || k == 4), 8'd9, (k == 4) ? 8'd6 : 8'd5,
          (k >= 1 && k < 4), (k % 5) < 2, (k % 5) == 4, "wrap_load");
    for (int k = 0; k < 20; k++)
      cyc(0, 1, 0, 8'd0, 8'd0, 0, (k % 10) < 6, (k % 10) == 9, "duty6");

    // duty 0: constant low.
    cyc(0, 0, 1, 8'd9, 8'd0, 0, 0, 0, "parked_load");
    for (int k = 0; k < 20; k++)
      cyc(0, 1, 0, 8'd0, 8'd0, 0, 0, (k % 10) == 9, "duty0");

    // duty > period: constant high across three wraps.
    cyc(0, 0, 1, 8'd9, 8'd12, 0, 0, 0, "parked_load");
    for (int k = 0; k < 30; k++)
      cyc(0, 1, 0, 8'd0, 8'd0, 0, 1, (k % 10) == 9, "duty_over");

    // period 0: strobe and output high every clock.
    cyc(0, 0, 1, 8'd0, 8'd1, 0, 0, 0, "parked_load");
    for (int k = 0; k < 5; k++)
      cyc(0, 1, 0, 8'd0, 8'd0, 0, 1, 1, "period0");

    // Reset at cnt=6 with a staged load pending; the staged period 4 must never appear.
    cyc(0, 0, 1, 8'd9, 8'd3, 0, 0, 0, "parked_load");
    for (int k = 0; k < 6; k++)
      cyc(0, 1, k == 3, 8'd4, 8'd2, k >= 3, k < 3, 0, "pre_reset");
    cyc(1, 1, 0, 8'd0, 8'd0, 0, 0, 0, "mid_reset");
    for (int k = 0; k < 260; k++)
      cyc(0, 1, 0, 8'd0, 8'd0, 0, 0, k == 255, "post_reset");

    // Enable dropped in the high phase, then restarted with the full high time.
    cyc(0, 0, 1, 8'd9, 8'd5, 0, 0, 0, "parked_load");
    for (int k = 0; k < 3; k++)
      cyc(0, 1, 0, 8'd0, 8'd0, 0, 1, 0, "gate_run");
    cyc(0, 0, 0, 8'd0, 8'd0, 0, 0, 0, "gate_off");
    for (int k = 0; k < 10; k++)
      cyc(0, 1, 0, 8'd0, 8'd0, 0, k < 5, k == 9, "gate_restart");

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain: got %0d queued, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pwm_gen.md
Name: pwm_gen

Overview:
- Programmable PWM source for the PWM project. Produces the raw PWM waveform that the downstream output-register stage (D_ff) retimes onto the pin.
- Up-counter with period and duty compare. Loads are double-buffered, so a new period/duty takes effect only on a period boundary and no runt pulses reach the output stage.
- Also emits a per-period strobe for software/sequencer use.

Parameters:
- WIDTH, 8: width of the counter, period and duty fields.
- RST_PERIOD, 255: period value loaded at reset. A PWM cycle lasts period+1 clocks.

Ports:
- clk  input  1  system clock; all logic on the posedge.
- rstn  input  1  synchronous, active-high reset. rstn=1 at a posedge resets the block.
- en  input  1  run enable. 0 = counter parked and output low.
- load  input  1  single-cycle strobe; captures period_in/duty_in.
- period_in  input  WIDTH  new period, terminal count (cycle length = period_in+1).
- duty_in  input  WIDTH  new duty, the number of high clocks per cycle.
- pend  output  1  staged values waiting for the next boundary.
- pwm_out  output  1  registered PWM waveform to D_ff.D.
- cycle_end  output  1  one-clock pulse per completed PWM cycle.

Behaviour:
- Reset (rstn=1 at posedge), overriding everything else:
  - cnt=0, period_q=RST_PERIOD, duty_q=0.
  - stage_period=RST_PERIOD, stage_duty=0.
  - pend=0, pwm_out=0, cycle_end=0.
  - Reset mid-cycle discards any staged load.
- Registers: active pair period_q/duty_q; staging pair stage_period/stage_duty; counter cnt (WIDTH bits).
- Load, en=1:
  - load=1 writes the staging pair and sets pend=1.
  - A load while pend=1 overwrites the staging pair; last load wins.
- Load, en=0: load=1 writes period_q/duty_q directly; pend stays 0.
- Counting, en=1:
  - If cnt==period_q: cnt<=0 (wrap). Otherwise cnt<=cnt+1.
  - No overflow is possible, since cnt never exceeds period_q.
- Boundary transfer, en=1 and cnt==period_q:
  - If pend=1: period_q<=stage_period, duty_q<=stage_duty, pend<=0.
  - If load=1 in the same cycle: period_in/duty_in bypass staging and go straight to period_q/duty_q; pend<=0.
- Output, en=1:
  - pwm_out <= (cnt < duty_q). Registered, so pwm_out lags cnt by one clock.
  - Per cycle: high for min(duty_q, period_q+1) clocks, then low.
  - duty_q=0 gives constant low. duty_q>period_q gives constant high with no glitch at wrap.
- cycle_end <= (en && cnt==period_q). It is high in the clock where cnt has just returned to 0, exactly once per cycle.
- en=0:
  - cnt<=0, pwm_out<=0, cycle_end<=0.
  - Staged values are retained, and pend is transferred on the first wrap after re-enable.
- Re-enable: the first rising edge after en goes 0→1 starts from cnt=0. pwm_out rises one clock after en if duty_q>0.
- period_q=0:
  - Each cycle is 1 clock and cycle_end is high continuously.
  - pwm_out is 1 iff duty_q≥1.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Basic waveform: rstn=1 for 2 clocks, then rstn=0; with en=0, load period=9, duty=3; set en=1. Required: pwm_out repeats 3 high / 7 low; cycle_end pulses every 10 clocks; pend stays 0.
- Double buffering: while running period=9/duty=3, at cnt=4 load period=4, duty=2. Required: pend=1 until the wrap; current cycle finishes as 3H/7L; next cycles are 2H/3L; pend=0 after the wrap.
- Same-cycle load at wrap plus overwrite: two loads (duty=5, then duty=6) in one period, the second landing on the cnt==period_q clock. Required: next cycle uses duty=6; pend=0.
- Extremes: duty=0 gives pwm_out constant 0. Period=9, duty=12 gives pwm_out constant 1 across 3 wraps with no low clock. Period=0, duty=1 gives pwm_out=1 and cycle_end=1 every clock.
- Reset mid-operation: rstn=1 at cnt=6 with pend=1. Required, the next clock: pwm_out=0, cycle_end=0, pend=0, cnt=0, period_q=255, duty_q=0; after release, no stale staged values are applied.
- Enable gating: drop en mid-high-phase. Required: pwm_out=0 and cnt=0 the next clock. Re-raise en: waveform restarts from the cycle start with the full duty high time.
